led_status_driver: RTL

- Multi-channel successor to the single-channel pulse stretcher that drives the board status LEDs.
- Each channel has a run-time mode:
  - off
  - retriggerable pulse extend
  - queued blink-per-event
  - free-running heartbeat
- Sits between status strobes (frame received, ID valid, error) and the LED pins.
- All timing is in clk cycles (50 MHz on board); benches use small parameter values.

---
 rtl/led_status_driver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/led_status_driver.sv
// Multi-channel status LED driver: off / pulse extend / queued blink /
// heartbeat per channel, with one shared heartbeat prescaler.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   pulse_in  per-channel status strobe (level-sampled)
//   mode      2 bits per channel: 00 off, 01 extend, 10 blink, 11 heartbeat
//   led_out   registered LED drive, 1 = lit
//   active    registered, 1 while an extend/blink sequence is running or queued
module led_status_driver #(
    parameter int NUM_CH            = 4,
    parameter int HOLD_CYCLES       = 50000000,
    parameter int BLINK_HALF_CYCLES = 12500000,
    parameter int MAX_PENDING       = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     pulse_in,
    input  logic [2*NUM_CH-1:0]   mode,
    output logic [NUM_CH-1:0]     led_out,
    output logic [NUM_CH-1:0]     active
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);

    localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0] HALF_TOP = BW'(BLINK_HALF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_EXT   = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_HB    = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    // Shared heartbeat timebase
    logic [BW-1:0] presc;
    logic          phase;
    logic          wrap;
    logic          phase_next;

    assign wrap       = (presc == HALF_TOP);
    assign phase_next = phase ^ wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= 1'b0;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            phase <= phase_next;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]    m, mq;
        logic [HW-1:0] hold, hold_b, hold_n;
        logic [1:0]    st, st_b, st_n;
        logic [BW-1:0] tmr, tmr_b, tmr_n;
        logic [PW-1:0] pend, pend_b, pend_i, pend_n;
        logic          prev, ev, chg;
        logic          led_q, act_q, led_n, act_n;

        assign m = mode[2*c +: 2];

        always_comb begin
            chg    = (m != mq);
            ev     = pulse_in[c] & ~prev;
            // A mode change starts the new mode from a cleared channel
            hold_b = chg ? '0 : hold;
            st_b   = chg ? S_IDLE : st;
            tmr_b  = chg ? '0 : tmr;
            pend_b = chg ? '0 : pend;
            hold_n = '0;
            st_n   = S_IDLE;
            tmr_n  = '0;
            pend_n = '0;
            pend_i = pend_b;
            led_n  = 1'b0;
            act_n  = 1'b0;
            case (m)
                M_EXT: begin
                    if (pulse_in[c])
                        hold_n = HOLD_V;
                    else if (hold_b != '0)
                        hold_n = hold_b - 1'b1;
                    led_n = (hold_n != '0);
                    act_n = led_n;
                end
                M_BLINK: begin
                    // Saturating enqueue first, then the OFF->ON dequeue,
                    // so an edge at OFF->IDLE restarts with no gap
                    if (ev && st_b != S_IDLE && pend_b != PEND_MAX)
                        pend_i = pend_b + 1'b1;
                    st_n   = st_b;
                    tmr_n  = tmr_b;
                    pend_n = pend_i;
                    case (st_b)
                        S_IDLE: begin
                            if (ev) begin
                                st_n  = S_ON;
                                tmr_n = HALF_TOP;
                            end
                        end
                        S_ON: begin
                            if (tmr_b == '0) begin
                                st_n  = S_OFF;
                                tmr_n = HALF_TOP;
                            end else begin
                                tmr_n = tmr_b - 1'b1;
                            end
                        end
                        S_OFF: begin
                            if (tmr_b == '0) begin
                                if (pend_i != '0) begin
                                    st_n   = S_ON;
                                    tmr_n  = HALF_TOP;
                                    pend_n = pend_i - 1'b1;
                                end else begin
                                    st_n   = S_IDLE;
                                    pend_n = '0;
                                end
                            end else begin
                                tmr_n = tmr_b - 1'b1;
                            end
                        end
                        default: begin
                            st_n   = S_IDLE;
                            pend_n = '0;
                        end
                    endcase
                    led_n = (st_n == S_ON);
                    act_n = (st_n != S_IDLE);
                end
                M_HB: begin
                    led_n = phase_next;
                end
                default: begin
                    led_n = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mq    <= M_OFF;
                hold  <= '0;
                st    <= S_IDLE;
                tmr   <= '0;
                pend  <= '0;
                prev  <= 1'b0;
                led_q <= 1'b0;
                act_q <= 1'b0;
            end else begin
                mq    <= m;
                hold  <= hold_n;
                st    <= st_n;
                tmr   <= tmr_n;
                pend  <= pend_n;
                prev  <= pulse_in[c];
                led_q <= led_n;
                act_q <= act_n;
            end
        end

        assign led_out[c] = led_q;
        assign active[c]  = act_q;
    end

endmodule
